// File: rtl/serializador_tupla6.sv
// ==========================================================================
// serializador_tupla6 : framed serial transmitter for a parallel tuple
//   frame = start(0), ANCHO data bits LSB first, parity, stop(1)
// Revision: 1.0
// ==========================================================================
`default_nettype none

module serializador_tupla6 #(
  parameter int ANCHO       = 6,
  parameter int DIV         = 4,
  parameter int PARIDAD_PAR = 1
) (
  input  logic             Reloj,
  input  logic             Reiniciar,
  input  logic [ANCHO-1:0] Tupla,
  input  logic             Valido,
  output logic             Listo,
  output logic             Salida,
  output logic             Ocupado,
  output logic             Fin
);

  localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_bit_w = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(DIV - 1);
  localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(ANCHO - 1);

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    INICIO  = 3'd1,
    DATOS   = 3'd2,
    PARIDAD = 3'd3,
    PARADA  = 3'd4
  } estado_t;

  estado_t            state_q, state_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic [c_bit_w-1:0] bit_q, bit_d;
  logic [ANCHO-1:0]   shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               salida_q, salida_d;
  logic               listo_q, listo_d;
  logic               ocupado_q, ocupado_d;
  logic               fin_q, fin_d;
  logic               wrap;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    fin_d   = 1'b0;
    wrap    = (div_q == c_div_max);

    if (state_q != REPOSO) begin
      div_d = wrap ? '0 : div_q + 1'b1;
    end

    case (state_q)
      REPOSO: begin
        if (Valido) begin
          state_d = INICIO;
          div_d   = '0;
          bit_d   = '0;
          shreg_d = Tupla;
          par_d   = (PARIDAD_PAR != 0) ? ^Tupla : ~(^Tupla);
        end
      end
      INICIO: begin
        if (wrap) begin
          state_d = DATOS;
          bit_d   = '0;
        end
      end
      DATOS: begin
        // The line always shows shreg_q[0]; shifting on wrap exposes the next bit.
        if (wrap) begin
          if (bit_q == c_bit_max) begin
            state_d = PARIDAD;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARIDAD: begin
        if (wrap) state_d = PARADA;
      end
      PARADA: begin
        if (wrap) begin
          state_d = REPOSO;
          fin_d   = 1'b1;
        end
      end
      default: state_d = REPOSO;
    endcase

    // Outputs are decoded from the next state so that they land in flops.
    case (state_d)
      INICIO:  salida_d = 1'b0;
      DATOS:   salida_d = shreg_d[0];
      PARIDAD: salida_d = par_d;
      default: salida_d = 1'b1;
    endcase
    listo_d   = (state_d == REPOSO);
    ocupado_d = ~listo_d;
  end

  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      state_q   <= REPOSO;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      salida_q  <= 1'b1;
      listo_q   <= 1'b1;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      salida_q  <= salida_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign Salida  = salida_q;
  assign Listo   = listo_q;
  assign Ocupado = ocupado_q;
  assign Fin     = fin_q;

endmodule

`default_nettype wire

// File: tb/tb_serializador_tupla6.sv
// ==========================================================================
// tb_serializador_tupla6 : directed table-driven bench, default and DIV=1/odd
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_serializador_tupla6;

  logic       Reloj = 1'b0;
  logic       Reiniciar = 1'b0;
  logic [5:0] tupla0 = '0, tupla1 = '0;
  logic       valido0 = 1'b0, valido1 = 1'b0;
  logic       listo0, salida0, ocupado0, fin0;
  logic       listo1, salida1, ocupado1, fin1;

  int total = 0;
  int bad   = 0;

  always #5 Reloj = ~Reloj;

  serializador_tupla6 dut0 (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Tupla(tupla0), .Valido(valido0),
    .Listo(listo0), .Salida(salida0), .Ocupado(ocupado0), .Fin(fin0)
  );

  serializador_tupla6 #(.ANCHO(6), .DIV(1), .PARIDAD_PAR(0)) dut1 (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Tupla(tupla1), .Valido(valido1),
    .Listo(listo1), .Salida(salida1), .Ocupado(ocupado1), .Fin(fin1)
  );

  typedef struct {
    int         sel;
    logic [5:0] tupla;
    logic [8:0] frame;  // bit k = line value of slot k
  } vec_t;

  vec_t vecs[6];

  // {Salida, Listo, Ocupado, Fin}
  function automatic logic [3:0] outs(int sel);
    return (sel == 0) ? {salida0, listo0, ocupado0, fin0}
                      : {salida1, listo1, ocupado1, fin1};
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {sal,listo,ocup,fin}=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(int sel, logic [5:0] t, logic v);
    if (sel == 0) begin tupla0 = t; valido0 = v; end
    else          begin tupla1 = t; valido1 = v; end
  endtask

  task automatic drive_v(int sel, logic v);
    if (sel == 0) valido0 = v;
    else          valido1 = v;
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic start(int sel, logic [5:0] t, bit hold);
    chk($sformatf("idle_before_accept%0d", sel), outs(sel), 4'b1100);
    drive(sel, t, 1'b1);
    @(posedge Reloj);
    @(negedge Reloj);
    if (!hold) drive_v(sel, 1'b0);
  endtask

  // Checks every cycle of the frame, then the Fin cycle; returns at the Fin-cycle negedge.
  task automatic check_body(int sel, logic [8:0] fr, int poke);
    int div;
    div = (sel == 0) ? 4 : 1;
    for (int k = 0; k < 9 * div; k++) begin
      chk($sformatf("frame%0d_slot%0d", sel, k), outs(sel), {fr[k / div], 1'b0, 1'b1, 1'b0});
      if (poke >= 0 && k == poke)          drive(sel, 6'h15, 1'b1);
      else if (poke >= 0 && k == poke + 1) drive_v(sel, 1'b0);
      @(negedge Reloj);
    end
    chk($sformatf("fin_pulse%0d", sel), outs(sel), 4'b1101);
  endtask

  task automatic finish_frame(int sel);
    drive_v(sel, 1'b0);
    @(negedge Reloj);
    chk($sformatf("after_fin%0d", sel), outs(sel), 4'b1100);
  endtask

  initial begin
    vecs[0] = '{0, 6'b101101, 9'b1_0_101101_0};
    vecs[1] = '{0, 6'h00,     9'b1_0_000000_0};
    vecs[2] = '{0, 6'h3F,     9'b1_0_111111_0};
    vecs[3] = '{1, 6'h3F,     9'b1_1_111111_0};
    vecs[4] = '{1, 6'h00,     9'b1_1_000000_0};
    vecs[5] = '{1, 6'h07,     9'b1_0_000111_0};

    // Reset held low across clock edges
    repeat (3) begin
      @(negedge Reloj);
      chk("reset0", outs(0), 4'b1100);
      chk("reset1", outs(1), 4'b1100);
    end
    Reiniciar = 1'b1;
    @(negedge Reloj);

    foreach (vecs[i]) begin
      start(vecs[i].sel, vecs[i].tupla, 1'b0);
      check_body(vecs[i].sel, vecs[i].frame, -1);
      finish_frame(vecs[i].sel);
    end

    // Back-to-back with Valido held high; second tuple presented in the Fin cycle
    start(0, 6'h01, 1'b1);
    check_body(0, 9'b1_1_000001_0, -1);
    tupla0 = 6'h02;
    @(posedge Reloj);
    @(negedge Reloj);
    valido0 = 1'b0;
    check_body(0, 9'b1_1_000010_0, -1);
    finish_frame(0);

    // Request mid-frame is ignored
    start(0, 6'h2A, 1'b0);
    check_body(0, 9'b1_1_101010_0, 9);
    finish_frame(0);

    // Asynchronous reset during DATOS
    start(0, 6'b101101, 1'b0);
    repeat (10) @(negedge Reloj);
    chk("pre_reset_datos", outs(0), 4'b0010);
    #1 Reiniciar = 1'b0;
    #1 chk("async_reset", outs(0), 4'b1100);
    repeat (2) begin
      @(negedge Reloj);
      chk("reset_held", outs(0), 4'b1100);
    end
    Reiniciar = 1'b1;
    repeat (3) begin
      @(negedge Reloj);
      chk("no_fin_after_reset", outs(0), 4'b1100);
    end
    start(0, 6'h15, 1'b0);
    check_body(0, 9'b1_1_010101_0, -1);
    finish_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serializador_tupla6.md
Name: serializador_tupla6

Overview:
- Reads the 6-bit tuple held in the 6-bit register's output and transmits it as a framed serial word on one line.
- Frame: start bit, 6 data bits LSB first, parity bit, stop bit.
- Acts as the read/transmit end of the tuple path; the register is the write end.
- Upstream hands over a tuple with a valid/ready handshake; downstream sees a constant-rate serial line plus an end-of-frame pulse.

Parameters:
- ANCHO, 6, data bits per frame (integer ≥ 1).
- DIV, 4, clock cycles per serial bit (integer ≥ 1).
- PARIDAD_PAR, 1, parity type: 1 = even parity, 0 = odd parity.

Ports:
- Reloj  input  1  clock; all state changes on rising edge.
- Reiniciar  input  1  asynchronous, active-low reset.
- Tupla  input  ANCHO  parallel tuple from the register output.
- Valido  input  1  upstream asserts that Tupla holds a word to send.
- Listo  output  1  block can accept a tuple this cycle.
- Salida  output  1  serial line; idles at 1.
- Ocupado  output  1  frame in progress.
- Fin  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (Reiniciar=0, asynchronous, takes effect without a clock edge):
  - State = REPOSO.
  - Salida=1, Listo=1, Ocupado=0, Fin=0.
  - Shift register, bit counter and divider counter cleared.
- Reset mid-frame aborts the frame immediately; no Fin pulse is produced. The first accept after release needs a Reloj edge.
- States: REPOSO, INICIO, DATOS, PARIDAD, PARADA.
- All outputs are registered.
- Listo is 1 exactly in REPOSO. Ocupado = NOT Listo.
- Transfer happens on a rising edge with Valido=1 and Listo=1. On that edge:
  - Tupla is captured.
  - Parity is computed: XOR of the tuple bits, inverted when PARIDAD_PAR=0.
  - State goes to INICIO and the divider loads 0.
- Valido while Ocupado=1 is ignored and is not queued. Changes to Tupla after capture have no effect.
- Each non-idle state lasts exactly DIV cycles; the divider counts 0..DIV-1.
- Line values per state:
  - INICIO: Salida=0.
  - DATOS: Salida = captured bit i, for i = 0..ANCHO-1, each held DIV cycles; bit counter advances on divider wrap.
  - PARIDAD: Salida = parity bit.
  - PARADA: Salida=1.
- Frame length = (ANCHO+3)·DIV cycles; with defaults, 36 cycles.
- Timing, with the accept edge at E0:
  - Salida first shows 0 after E0.
  - On edge E0+(ANCHO+3)·DIV: state returns to REPOSO, Fin=1 for exactly one cycle, Listo=1 in that same cycle.
- Back-to-back: if Valido=1 during the Fin cycle, the next frame starts with no extra idle cycle.
- DIV=1: every state lasts one cycle; Fin still pulses for one cycle.
- Counter widths are sized from ANCHO and DIV (ceiling log2, minimum 1 bit).

Test Plan:
- Reset values: hold Reiniciar=0, toggle Reloj → Salida=1, Listo=1, Ocupado=0, Fin=0 on every cycle.
- Single frame, defaults:
  - Stimulus: Tupla=6'b101101, Valido=1 for one accept edge.
  - Salida, each value held 4 cycles: 0, 1,0,1,1,0,1, 0 (parity), 1.
  - Fin pulse 36 cycles after the accept edge; Ocupado=1 throughout the frame.
- Odd parity with DIV=1, PARIDAD_PAR=0:
  - Stimulus: Tupla=6'h3F.
  - Salida: 0, 1,1,1,1,1,1, 1 (parity), 1.
  - Fin 9 cycles after accept.
- Back-to-back: Valido held at 1; Tupla=6'h01, then 6'h02 presented in the Fin cycle.
  - Second start bit begins the cycle after Fin.
  - No idle cycle between frames; both frames' data correct.
- Ignored request: pulse Valido=1 with Tupla=6'h15 mid-frame → no effect; frame content unchanged; Listo stays 0.
- Reset mid-frame: assert Reiniciar=0 during DATOS.
  - Salida=1 and Listo=1 immediately, with no clock edge.
  - No Fin pulse.
  - After release, a new frame transmits correctly.
